// File: rtl/apb_regfile_slave_pkg.sv
// +--------------------------------------------------------------------+
// | apb_pkg : shared types and helpers for the APB register-file slave  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam int c_wait_cnt_w = 4;

  function automatic int byte_off_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regfile_slave_if.sv
// +--------------------------------------------------------------------+
// | apb_regfile_slave_if : APB3/APB4 bus bundle with master/slave views |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface apb_regfile_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

`default_nettype wire

// File: rtl/apb_regfile_slave_wait_ctrl.sv
// +--------------------------------------------------------------------+
// | apb_wait_ctrl : APB slave FSM with programmable wait-state counter  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module apb_wait_ctrl
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  wire logic PCLK,
  input  wire logic PRESETn,
  input  wire logic psel,
  input  wire logic penable,
  output logic      ready,
  output logic      done
);

  apb_slv_state_e          r_state, w_state_nxt;
  logic [c_wait_cnt_w-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ready depends only on state/counter; psel merely qualifies the done strobe
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = c_wait_cnt_w'(WAIT_STATES);
        end
      end
      ACCESS: begin
        ready = (r_cnt == '0);
        if (!psel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          done        = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_wait_cnt_w'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/apb_regfile_slave.sv
// +--------------------------------------------------------------------+
// | apb_regfile_slave : parametrised APB register file with strobes,    |
// | wait states, read-only masking and error responses.  Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_REGS    = 4,
  parameter int                    WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic                           PCLK,
  input  wire logic                           PRESETn,
  apb_regfile_slave_if.slave                  apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0]      reg_out,
  input  wire logic [NUM_REGS*DATA_WIDTH-1:0] ro_in
);

  localparam int c_nbytes = DATA_WIDTH / 8;
  localparam int c_off_w  = byte_off_w(DATA_WIDTH);

  logic                  w_ready, w_done;
  logic                  w_misaligned, w_in_range, w_ro_hit, w_err, w_wr_en;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .psel    (apb.PSEL),
    .penable (apb.PENABLE),
    .ready   (w_ready),
    .done    (w_done)
  );

  assign w_idx = apb.PADDR >> c_off_w;

  generate
    if (c_off_w == 0) begin : g_no_offset
      assign w_misaligned = 1'b0;
    end else begin : g_offset
      assign w_misaligned = |apb.PADDR[c_off_w-1:0];
    end
  endgenerate

  assign w_in_range = 32'(w_idx) < 32'(NUM_REGS);

  // full-width index compare so out-of-range addresses never alias a register
  always_comb begin
    w_ro_hit  = 1'b0;
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == ADDR_WIDTH'(i)) begin
        w_ro_hit  = RO_MASK[i];
        w_rd_word = w_regs[i];
      end
    end
  end

  assign w_err   = w_misaligned || !w_in_range || (apb.PWRITE && w_ro_hit);
  assign w_wr_en = w_done && apb.PWRITE && !w_err;

  assign apb.PREADY  = w_ready;
  assign apb.PSLVERR = w_ready && w_err;
  assign apb.PRDATA  = (w_ready && !apb.PWRITE && !w_err) ? w_rd_word : '0;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (RO_MASK[i]) begin : g_ro
        assign w_regs[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_rw
        logic [DATA_WIDTH-1:0] r_reg;
        logic                  w_ro_in_unused;

        assign w_ro_in_unused = ^ro_in[i*DATA_WIDTH +: DATA_WIDTH];

        always_ff @(posedge PCLK or negedge PRESETn) begin
          if (!PRESETn) begin
            r_reg <= RESET_VALUE;
          end else if (w_wr_en && (w_idx == ADDR_WIDTH'(i))) begin
            for (int b = 0; b < c_nbytes; b++) begin
              if (apb.PSTRB[b]) r_reg[b*8 +: 8] <= apb.PWDATA[b*8 +: 8];
            end
          end
        end

        assign w_regs[i] = r_reg;
      end
      assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = w_regs[i];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
// +--------------------------------------------------------------------+
// | tb_apb_regfile_slave : directed self-checking bench, three configs  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_apb_regfile_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sel = '0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [63:0] pwdata = '0;
  logic [7:0] pstrb = '0;

  always #5 clk = ~clk;

  localparam logic [127:0] c_ro_a = {4{32'hEEEE_EEEE}};
  localparam logic [127:0] c_ro_b = 128'h0000_0000_0000_0000_5A5A_5A5A_0000_0000;
  localparam logic [127:0] c_ro_c = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;

  apb_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
  apb_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();
  apb_regfile_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus_c ();

  assign bus_a.PSEL = sel[0]; assign bus_a.PENABLE = penable; assign bus_a.PWRITE = pwrite;
  assign bus_a.PADDR = paddr; assign bus_a.PWDATA = pwdata[31:0]; assign bus_a.PSTRB = pstrb[3:0];
  assign bus_b.PSEL = sel[1]; assign bus_b.PENABLE = penable; assign bus_b.PWRITE = pwrite;
  assign bus_b.PADDR = paddr; assign bus_b.PWDATA = pwdata[31:0]; assign bus_b.PSTRB = pstrb[3:0];
  assign bus_c.PSEL = sel[2]; assign bus_c.PENABLE = penable; assign bus_c.PWRITE = pwrite;
  assign bus_c.PADDR = paddr; assign bus_c.PWDATA = pwdata[15:0]; assign bus_c.PSTRB = pstrb[1:0];

  logic [127:0] reg_out_a, reg_out_b, reg_out_c;

  apb_regfile_slave dut_a (
    .PCLK(clk), .PRESETn(rst_n), .apb(bus_a), .reg_out(reg_out_a), .ro_in(c_ro_a)
  );
  apb_regfile_slave #(.WAIT_STATES(3), .RO_MASK(4'b0010), .RESET_VALUE(32'h0BAD_F00D)) dut_b (
    .PCLK(clk), .PRESETn(rst_n), .apb(bus_b), .reg_out(reg_out_b), .ro_in(c_ro_b)
  );
  apb_regfile_slave #(.DATA_WIDTH(16), .NUM_REGS(8), .WAIT_STATES(1), .RO_MASK(8'h00),
                      .RESET_VALUE(16'h1234)) dut_c (
    .PCLK(clk), .PRESETn(rst_n), .apb(bus_c), .reg_out(reg_out_c), .ro_in(c_ro_c)
  );

  int          p_dw  [3] = '{32, 32, 16};
  int          p_n   [3] = '{4, 4, 8};
  int          p_ws  [3] = '{0, 3, 1};
  logic [7:0]  p_ro  [3] = '{8'h00, 8'h02, 8'h00};
  logic [63:0] p_rst [3] = '{64'h0, 64'h0BAD_F00D, 64'h1234};

  logic [63:0] m_reg [3][8];
  logic        exp_ready [3] = '{1'b0, 1'b0, 1'b0};
  logic        exp_err   [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] exp_rdata [3] = '{64'h0, 64'h0, 64'h0};
  logic        run_cmp = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] dmask(input int d);
    return (64'd1 << p_dw[d]) - 64'd1;
  endfunction

  function automatic logic [63:0] ro_val(input int d, input int i);
    logic [127:0] v;
    v = (d == 0) ? c_ro_a : (d == 1) ? c_ro_b : c_ro_c;
    return 64'(v >> (i * p_dw[d])) & dmask(d);
  endfunction

  function automatic logic [127:0] model_flat(input int d);
    logic [127:0] v;
    logic [63:0]  w;
    v = '0;
    for (int i = 0; i < p_n[d]; i++) begin
      w = p_ro[d][i] ? ro_val(d, i) : m_reg[d][i];
      v = v | (128'(w & dmask(d)) << (i * p_dw[d]));
    end
    return v;
  endfunction

  function automatic logic dut_ready(input int d);
    return (d == 0) ? bus_a.PREADY : (d == 1) ? bus_b.PREADY : bus_c.PREADY;
  endfunction
  function automatic logic dut_err(input int d);
    return (d == 0) ? bus_a.PSLVERR : (d == 1) ? bus_b.PSLVERR : bus_c.PSLVERR;
  endfunction
  function automatic logic [63:0] dut_rdata(input int d);
    return (d == 0) ? 64'(bus_a.PRDATA) : (d == 1) ? 64'(bus_b.PRDATA) : 64'(bus_c.PRDATA);
  endfunction
  function automatic logic [127:0] dut_flat(input int d);
    return (d == 0) ? reg_out_a : (d == 1) ? reg_out_b : reg_out_c;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) m_reg[d][i] = p_rst[d] & dmask(d);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("pready[%0d]", d), 128'(dut_ready(d)), 128'(exp_ready[d]));
        if (exp_ready[d]) chk($sformatf("pslverr[%0d]", d), 128'(dut_err(d)), 128'(exp_err[d]));
        chk($sformatf("prdata[%0d]", d), 128'(dut_rdata(d)), 128'(exp_rdata[d]));
        chk($sformatf("reg_out[%0d]", d), dut_flat(d), model_flat(d));
      end
    end
  end

  // One APB transfer; abort_at >= 0 drops PSEL in that wait cycle instead of completing.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [63:0] wd,
                      input logic [7:0] st, input int abort_at,
                      output logic [63:0] rd, output logic err_o);
    int nb, idx;
    bit e;
    logic [63:0] er;
    nb  = p_dw[d] / 8;
    idx = addr / nb;
    e   = ((addr % nb) != 0) || (idx >= p_n[d]);
    if (!e && wr && p_ro[d][idx]) e = 1'b1;
    er = '0;
    if (!wr && !e) er = p_ro[d][idx] ? ro_val(d, idx) : m_reg[d][idx];
    rd = '0;
    err_o = 1'b0;
    sel = 3'b001 << d; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 0; k < p_ws[d]; k++) begin
      if (k == abort_at) begin
        sel = '0; penable = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    exp_ready[d] = 1'b1; exp_err[d] = e; exp_rdata[d] = er;
    #2;
    rd = dut_rdata(d);
    err_o = dut_err(d);
    chk($sformatf("done_ready[%0d]@%h", d, addr), 128'(dut_ready(d)), 128'(1'b1));
    @(posedge clk);
    if (wr && !e)
      for (int b = 0; b < nb; b++) if (st[b]) m_reg[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    #1 sel = '0; penable = 1'b0;
    exp_ready[d] = 1'b0; exp_err[d] = 1'b0; exp_rdata[d] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready_a", 128'(bus_a.PREADY), 128'(1'b0));
    chk("rst_prdata_a", 128'(bus_a.PRDATA), 128'h0);
    chk("rst_pslverr_b", 128'(bus_b.PSLVERR), 128'(1'b0));
    chk("rst_regs_a", reg_out_a, 128'h0);
    chk("rst_regs_b", reg_out_b, 128'h0BADF00D_0BADF00D_5A5A5A5A_0BADF00D);
    chk("rst_regs_c", reg_out_c, {8{16'h1234}});
    #2 rst_n = 1'b1;
    @(posedge clk); #1 run_cmp = 1'b1;

    // config A: zero wait states, all RW
    xfer(0, 1, 8'h04, 64'hDEAD_BEEF, 8'hF, -1, rd, er);
    xfer(0, 0, 8'h04, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_deadbeef", rd, 128'hDEAD_BEEF);
    chk("a_rd_deadbeef_err", 128'(er), 128'(1'b0));
    xfer(0, 1, 8'h08, 64'h1122_3344, 8'hF, -1, rd, er);
    xfer(0, 1, 8'h08, 64'hAABB_CCDD, 8'h5, -1, rd, er);
    xfer(0, 0, 8'h08, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_strobe_merge", rd, 128'h11BB_33DD);
    xfer(0, 1, 8'h0C, 64'h9999_9999, 8'h0, -1, rd, er);
    xfer(0, 0, 8'h0C, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_nostrobe", rd, 128'h0);
    xfer(0, 1, 8'h02, 64'h7777_7777, 8'hF, -1, rd, er);
    chk("a_wr_misaligned_err", 128'(er), 128'(1'b1));
    xfer(0, 0, 8'h02, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_misaligned_err", 128'(er), 128'(1'b1));
    xfer(0, 1, 8'h10, 64'h6666_6666, 8'hF, -1, rd, er);
    chk("a_wr_range_err", 128'(er), 128'(1'b1));
    xfer(0, 0, 8'h10, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_range_data", rd, 128'h0);

    // config B: three wait states, register 1 read-only
    xfer(1, 0, 8'h04, 64'h0, 8'h0, -1, rd, er);
    chk("b_rd_ro", rd, 128'h5A5A_5A5A);
    xfer(1, 1, 8'h04, 64'h1234_5678, 8'hF, -1, rd, er);
    chk("b_wr_ro_err", 128'(er), 128'(1'b1));
    xfer(1, 0, 8'h00, 64'h0, 8'h0, -1, rd, er);
    chk("b_rd_reset_value", rd, 128'h0BAD_F00D);
    xfer(1, 1, 8'h00, 64'h1234_5678, 8'hF, -1, rd, er);
    xfer(1, 1, 8'h00, 64'hFFFF_FFFF, 8'hF, 1, rd, er);
    xfer(1, 0, 8'h00, 64'h0, 8'h0, -1, rd, er);
    chk("b_rd_after_abort", rd, 128'h1234_5678);
    xfer(1, 0, 8'h10, 64'h0, 8'h0, -1, rd, er);
    chk("b_rd_range_err", 128'(er), 128'(1'b1));

    // config C: 16-bit bus, eight registers, back-to-back writes
    xfer(2, 1, 8'h0E, 64'hBEEF, 8'h3, -1, rd, er);
    xfer(2, 1, 8'h00, 64'h00A5, 8'h1, -1, rd, er);
    chk("c_reg7_slice", 128'(reg_out_c[127:112]), 128'hBEEF);
    chk("c_reg0_slice", 128'(reg_out_c[15:0]), 128'h12A5);
    xfer(2, 0, 8'h0E, 64'h0, 8'h0, -1, rd, er);
    chk("c_rd_reg7", rd, 128'hBEEF);
    xfer(2, 1, 8'h01, 64'h5555, 8'h3, -1, rd, er);
    chk("c_wr_misaligned_err", 128'(er), 128'(1'b1));

    // reset asserted during the access phase of a write
    sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 64'hFFFF_FFFF; pstrb = 8'hF;
    @(posedge clk); #1 penable = 1'b1;
    exp_ready[0] = 1'b1; exp_err[0] = 1'b0; exp_rdata[0] = '0;
    #2 rst_n = 1'b0;
    model_reset();
    exp_ready[0] = 1'b0;
    #1;
    chk("arst_pready", 128'(bus_a.PREADY), 128'(1'b0));
    chk("arst_prdata", 128'(bus_a.PRDATA), 128'h0);
    chk("arst_pslverr", 128'(bus_a.PSLVERR), 128'(1'b0));
    chk("arst_reg_out_a", reg_out_a, 128'h0);
    sel = '0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 8'h08, 64'h0, 8'h0, -1, rd, er);
    chk("a_rd_after_reset", rd, 128'h0);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB3/APB4 completer exposing `NUM_REGS` word-aligned registers of `DATA_WIDTH` bits. It supports byte strobes, programmable wait states, per-register read-only masking, and error responses for bad accesses. It replaces the fixed 4x32-bit APB slave memory. It sits behind the APB bridge/decoder and presents register contents to core logic through flattened outputs.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: bus width; must be 8, 16, 32 or 64.
- `ADDR_WIDTH`, default 8: `PADDR` width.
- `NUM_REGS`, default 4: number of registers, at least 1; register i is at byte address i*(DATA_WIDTH/8).
- `WAIT_STATES`, default 0: access-phase cycles with `PREADY`=0 before completion, 0..15.
- `RO_MASK`, default 0: `NUM_REGS` bits; bit i=1 makes register i read-only, and its read data comes from `ro_in`.
- `RESET_VALUE`, default 0: `DATA_WIDTH` value loaded into every RW register on reset.

Ports:
- `PCLK`, in, 1: clock. Everything is on the rising edge.
- `PRESETn`, in, 1: asynchronous active-low reset.
- `PSEL`, in, 1: select.
- `PENABLE`, in, 1: access phase.
- `PWRITE`, in, 1: 1=write, 0=read.
- `PADDR`, in, `ADDR_WIDTH`: byte address.
- `PWDATA`, in, `DATA_WIDTH`: write data.
- `PSTRB`, in, `DATA_WIDTH`/8: write byte enables.
- `PRDATA`, out, `DATA_WIDTH`: read data, valid only while `PREADY`=1 on a read.
- `PREADY`, out, 1: transfer completes this cycle.
- `PSLVERR`, out, 1: error, valid only while `PREADY`=1.
- `reg_out`, out, `NUM_REGS`*`DATA_WIDTH`: register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ro_in`, in, `NUM_REGS`*`DATA_WIDTH`: read source for RO registers; ignored for RW registers.

## Operation
- FSM states:
  - IDLE: leaves only on `PSEL`&!`PENABLE` (setup phase). The wait counter loads `WAIT_STATES`, then the FSM moves to ACCESS.
  - ACCESS: if `PSEL`=0, abort to IDLE with no side effects. Otherwise, when counter=0, `PREADY`=1 and the FSM goes to IDLE on the next edge. Otherwise the counter decrements.
- `PSEL`&`PENABLE` seen in IDLE without a preceding setup is a protocol violation: ignored, `PREADY` stays 0.
- Decode: `idx` = `PADDR` >> log2(DATA_WIDTH/8). An error is flagged if any of these hold:
  - `PADDR` low bits are nonzero (misaligned);
  - `idx` >= `NUM_REGS`;
  - write to a register with `RO_MASK`[idx]=1.
- Completion cycle (`PREADY`=1):
  - `PSLVERR` = error.
  - Write without error: register bytes with `PSTRB`[b]=1 take `PWDATA` bytes; the other bytes are kept. `PSTRB`=0 is a legal no-op write.
  - Read without error: `PRDATA` = `ro_in` slice if RO, else the register.
- Errored access: no register changes, `PRDATA`=0.
- Outside read completion, `PRDATA`=0.
- `PADDR`, `PWRITE`, `PWDATA` and `PSTRB` are sampled in the completion cycle. The APB master holds them stable from setup.
- Reset values: `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, FSM=IDLE, counter=0, RW registers=`RESET_VALUE`. RO registers are not stored.
- Reset mid-transfer: the transfer is dropped and the register is not written.

## Timing
- `PREADY`, `PSLVERR` and `PRDATA` are combinational from FSM state, counter and decoded registers. There is no combinational path from `PSEL` or `PENABLE` to `PREADY` other than gating by state.
- `WAIT_STATES`=N:
  - setup at T0;
  - `PREADY`=1 at T1+N;
  - the written value appears on `reg_out` at T2+N.
- Back-to-back transfers: a new setup in the cycle after completion starts immediately. Minimum throughput is one transfer per 2+N cycles.
- A read of a register in the cycle after a write to it returns the new value.

## Structure
- `apb_pkg`: `apb_slv_state_e` {IDLE, ACCESS}, the `WAIT_STATES` counter width constant (4), and a function computing the byte-offset width from `DATA_WIDTH`.
- Sub-module `apb_wait_ctrl`: holds the FSM and wait counter; outputs `PREADY` and an access-done strobe.
- The top holds decode, strobe merge and the register array.

## Test plan
- Default params: write 0xDEADBEEF to 0x04 with `PSTRB`=0xF, read 0x04 -> `PRDATA`=0xDEADBEEF, `PSLVERR`=0, `PREADY` in the first access cycle.
- `PSTRB`=0b0101 writing 0xAABBCCDD over 0x11223344 -> register reads 0x11BB33DD.
- `WAIT_STATES`=3: read -> `PREADY` low for 3 access cycles, high on the 4th; `PSEL` dropped after 1 wait cycle -> no write, FSM back to IDLE.
- Error cases, each with `PSLVERR`=1 and no register change:
  - misaligned address 0x02;
  - out-of-range address 0x10 with `NUM_REGS`=4;
  - write to RO register 1 with `RO_MASK`=4'b0010 (a read of it returns the `ro_in` value 0x5A5A5A5A).
- Assert `PRESETn` during the access phase of a write of 0xFFFFFFFF -> the register reads `RESET_VALUE` and the outputs are 0 asynchronously.
- `DATA_WIDTH`=16, `NUM_REGS`=8: back-to-back writes to 0x0E and 0x00 -> both land, `reg_out`[127:112]=written value.
